sdsu_alu_slave: RTL and testbench

Parametrised successor to the single-function multiply slave on the SDSU bus.
- Holds two operand registers, written through the same address-decoded valid/start bus.
- On command, runs MUL, ADD, SUB or PASS. MUL goes through a pipelined multiplier of configurable latency.
- Adds busy, overflow and error signalling, plus synchronous reset.
- Sits between the bus master and the register file, which consumes result_data on write.

---
 rtl/sdsu_bus_pkg.sv | 26 ++
 rtl/sdsu_pipe_mul.sv | 35 +++
 rtl/sdsu_alu_slave.sv | 157 +++++++++++++++
 tb/tb_sdsu_alu_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdsu_bus_pkg.sv
// sdsu_bus_pkg: shared opcode, state and address definitions for the SDSU ALU slave.
// Rev 1.0
`default_nettype none

package sdsu_bus_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_PASS = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int unsigned ADDR_CMD = 0;
  localparam int unsigned ADDR_OPA = 1;
  localparam int unsigned ADDR_OPB = 2;

endpackage

`default_nettype wire

// File: rtl/sdsu_pipe_mul.sv
// sdsu_pipe_mul: MUL_LAT-stage registered unsigned multiplier, full-width product.
// Rev 1.0
`default_nettype none

module sdsu_pipe_mul #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   p
);

  logic [2*DATA_W-1:0] stage [MUL_LAT];
  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Free-running pipe: stage k holds the product of the operands seen k+1 edges ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LAT-1];

endmodule

`default_nettype wire

// File: rtl/sdsu_alu_slave.sv
// sdsu_alu_slave: SDSU bus slave with operand registers and MUL/ADD/SUB/PASS execution.
// Rev 1.0
`default_nettype none

module sdsu_alu_slave
  import sdsu_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] register_data,
  output logic              exec,
  output logic              write,
  output logic              ready,
  output logic              busy,
  output logic              overflow,
  output logic              err,
  output logic [DATA_W-1:0] result_data
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e              state, state_n;
  opcode_e             op_q, op_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   opa, opa_n, opb, opb_n;
  logic [DATA_W-1:0]   res_q, res_n;
  logic                ovf_q, ovf_n;
  logic                exec_q, exec_n, err_q, err_n, busy_q, busy_n, ready_q, ready_n;
  logic                accept;
  logic [DATA_W:0]     sum, diff;
  logic [2*DATA_W-1:0] prod;

  sdsu_pipe_mul #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (opa),
    .b   (opb),
    .p   (prod)
  );

  assign sum    = {1'b0, opa} + {1'b0, opb};
  assign diff   = {1'b0, opa} - {1'b0, opb};
  assign accept = valid && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_MUL;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      exec_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      cnt     <= cnt_n;
      opa     <= opa_n;
      opb     <= opb_n;
      res_q   <= res_n;
      ovf_q   <= ovf_n;
      exec_q  <= exec_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      ready_q <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt;
    opa_n   = opa;
    opb_n   = opb;
    res_n   = res_q;
    ovf_n   = ovf_q;
    exec_n  = 1'b0;
    err_n   = 1'b0;
    busy_n  = 1'b0;
    ready_n = 1'b0;

    case (state)
      COMPUTE: begin
        if (cnt == '0) begin
          state_n = DONE;
          ready_n = 1'b1;
          case (op_q)
            OP_MUL: begin
              res_n = prod[DATA_W-1:0];
              ovf_n = |prod[2*DATA_W-1:DATA_W];
            end
            OP_ADD: begin
              res_n = sum[DATA_W-1:0];
              ovf_n = sum[DATA_W];
            end
            OP_SUB: begin
              res_n = diff[DATA_W-1:0];
              ovf_n = diff[DATA_W];
            end
            default: begin
              res_n = opa;
              ovf_n = 1'b0;
            end
          endcase
        end else begin
          cnt_n  = cnt - 1'b1;
          // Busy lags the command by one edge so it drops exactly as ready rises.
          busy_n = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (accept) begin
      exec_n = 1'b1;
      if (address == ADDR_W'(ADDR_OPA)) begin
        opa_n = register_data;
      end else if (address == ADDR_W'(ADDR_OPB)) begin
        opb_n = register_data;
      end else if (address == ADDR_W'(ADDR_CMD)) begin
        if (start) begin
          op_n    = opcode_e'(register_data[1:0]);
          state_n = COMPUTE;
          cnt_n   = (opcode_e'(register_data[1:0]) == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
        end
      end else begin
        err_n = 1'b1;
      end
    end
  end

  assign exec        = exec_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign write       = ready_q;
  assign overflow    = ovf_q;
  assign result_data = res_q;

endmodule

`default_nettype wire

// File: tb/tb_sdsu_alu_slave.sv
// tb_sdsu_alu_slave: vector table, hand sequences and randomized model checks for sdsu_alu_slave.
// Rev 1.0
`default_nettype none

module tb_sdsu_alu_slave;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int MUL_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic              start;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] register_data;
  logic              exec, write, ready, busy, overflow, err;
  logic [DATA_W-1:0] result_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdsu_alu_slave #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid         (valid),
    .start         (start),
    .address       (address),
    .register_data (register_data),
    .exec          (exec),
    .write         (write),
    .ready         (ready),
    .busy          (busy),
    .overflow      (overflow),
    .err           (err),
    .result_data   (result_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic from plain 64-bit integer math; returns {overflow, result}.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (op)
      2'd0: begin
        r = ua * ub;
        return {r >= 64'h1_0000_0000, r[31:0]};
      end
      2'd1: begin
        r = ua + ub;
        return {r >= 64'h1_0000_0000, r[31:0]};
      end
      2'd2: return {a < b, a - b};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic idle_inputs();
    valid         = 1'b0;
    start         = 1'b0;
    address       = '0;
    register_data = '0;
  endtask

  // One transfer: drive after a negedge, sample at the following negedge.
  task automatic xfer(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data, input logic st);
    valid         = 1'b1;
    start         = st;
    address       = addr;
    register_data = data;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic write_op(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data, input string tag);
    xfer(addr, data, 1'b1);
    check({tag, " wr exec"}, 64'(exec), 64'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] exp_res, input logic exp_ovf, input string tag);
    int          lat;
    int          nbusy;
    int          exp_lat;
    bit          seen;
    logic [31:0] cmd;
    exp_lat  = (op == 2'd0) ? MUL_LAT : 1;
    cmd      = $urandom;
    cmd[1:0] = op;
    xfer('0, cmd, 1'b1);
    check({tag, " cmd exec"}, 64'(exec), 64'd1);
    check({tag, " busy/ready after accept"}, {62'd0, busy, ready}, 64'd0);
    seen  = 1'b0;
    nbusy = 0;
    lat   = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        lat  = k;
      end else if (busy) begin
        nbusy++;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    check({tag, " write/busy at ready"}, {62'd0, write, busy}, 64'b10);
    check({tag, " result"}, 64'(result_data), 64'(exp_res));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [31:0] ma, mb;
    logic [32:0] exp;
    logic [1:0]  rop;

    vecs[0] = '{2'd0, 32'd6,          32'd7,          32'd42,         1'b0};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    vecs[2] = '{2'd2, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b1};
    vecs[3] = '{2'd3, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1'b0};
    vecs[4] = '{2'd0, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1};
    vecs[5] = '{2'd1, 32'd2,          32'd3,          32'd5,          1'b0};
    vecs[6] = '{2'd2, 32'd7,          32'd5,          32'd2,          1'b0};
    vecs[7] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b1};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset flags", {58'd0, exec, write, ready, busy, overflow, err}, 64'd0);
      check("reset result", 64'(result_data), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      write_op(ADDR_W'(1), vecs[i].a, $sformatf("vec%0d", i));
      write_op(ADDR_W'(2), vecs[i].b, $sformatf("vec%0d", i));
      run_cmd(vecs[i].op, vecs[i].res, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Busy rejection: operand writes during a MUL must be dropped.
    write_op(ADDR_W'(1), 32'h0001_0000, "busy");
    write_op(ADDR_W'(2), 32'h0001_0000, "busy");
    xfer('0, 32'd0, 1'b1);
    check("busy cmd exec", 64'(exec), 64'd1);
    xfer(ADDR_W'(1), 32'd9, 1'b1);
    check("busy wr1 exec/err", {62'd0, exec, err}, 64'd0);
    check("busy wr1 busy", 64'(busy), 64'd1);
    xfer(ADDR_W'(1), 32'd9, 1'b1);
    check("busy wr2 exec/err", {62'd0, exec, err}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("busy ready/write", {62'd0, ready, write}, 64'b11);
    check("busy result", 64'(result_data), 64'd0);
    check("busy overflow", 64'(overflow), 64'd1);
    run_cmd(2'd3, 32'h0001_0000, 1'b0, "busy pass");

    // Decode error and no-op command.
    xfer(ADDR_W'(5), 32'h1234, 1'b1);
    check("decode exec/err", {62'd0, exec, err}, 64'b11);
    @(posedge clk);
    @(negedge clk);
    check("decode pulse end", {62'd0, exec, err}, 64'd0);
    xfer(32'h8000_0001, 32'h55, 1'b0);
    check("decode hi exec/err", {62'd0, exec, err}, 64'b11);
    run_cmd(2'd3, 32'h0001_0000, 1'b0, "opa intact");
    xfer('0, 32'd1, 1'b0);
    check("noop exec/err", {62'd0, exec, err}, 64'b10);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("noop no ready", {62'd0, ready, busy}, 64'd0);
    end

    // Reset one cycle after a MUL command aborts it.
    write_op(ADDR_W'(1), 32'd3, "rstmid");
    write_op(ADDR_W'(2), 32'd4, "rstmid");
    xfer('0, 32'd0, 1'b1);
    check("rstmid cmd exec", 64'(exec), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rstmid flags", {58'd0, exec, write, ready, busy, overflow, err}, 64'd0);
      check("rstmid result", 64'(result_data), 64'd0);
    end
    run_cmd(2'd3, 32'd0, 1'b0, "rstmid opa");
    run_cmd(2'd1, 32'd0, 1'b0, "rstmid opb");

    // Randomized operations against the reference model.
    ma = 32'd0;
    mb = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ma = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
        write_op(ADDR_W'(1), ma, $sformatf("rnd%0d", i));
      end
      if ($urandom_range(0, 3) != 0) begin
        mb = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
        write_op(ADDR_W'(2), mb, $sformatf("rnd%0d", i));
      end
      rop = 2'($urandom_range(0, 3));
      exp = model(rop, ma, mb);
      run_cmd(rop, exp[31:0], exp[32], $sformatf("rnd%0d op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
